// File: rtl/gshare_pkg.sv
// Shared types and widths for the gshare update controller slice.
// The PHT index / GHR, BTB tag and target widths are fixed here because the
// in-flight entry struct depends on them.
package gshare_pkg;

    localparam int IDX_W  = 7;
    localparam int TAG_W  = 24;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        UPDATE  = 2'd1,
        RECOVER = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic [IDX_W-1:0] ghr;
        logic             taken;
    } inflight_t;

    // History as it should have been: pre-shift GHR plus the real outcome.
    function automatic logic [IDX_W-1:0] corrected_ghr(
        input logic [IDX_W-1:0] ghr,
        input logic             taken
    );
        return {ghr[IDX_W-2:0], taken};
    endfunction

endpackage

// File: rtl/gshare_inflight_fifo.sv
// Program-order queue of in-flight predictions. Flush wins over push/pop.
module gshare_inflight_fifo
    import gshare_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  inflight_t din,
    output inflight_t head,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    inflight_t        mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [OCC_W-1:0] count_r;
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_s    = (count_r == OCC_W'(DEPTH));
    assign empty_s   = (count_r == {OCC_W{1'b0}});
    assign push_ok_s = push && !full_s && !flush;
    assign pop_ok_s  = pop && !empty_s && !flush;

    assign head  = mem_r[rd_ptr_r];
    assign full  = full_s;
    assign empty = empty_s;

    // Entry storage; only written on an accepted push.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {OCC_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + OCC_W'(1);
                2'b01:   count_r <= count_r - OCC_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/gshare_update_ctrl.sv
// Sequences PHT/BTB updates for resolving branches in program order and
// restores the global history (and flushes wrong-path entries) on mispredict.
module gshare_update_ctrl
    import gshare_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pred_valid,
    input  logic [IDX_W-1:0]  pred_index,
    input  logic [IDX_W-1:0]  pred_ghr,
    input  logic              pred_taken,
    output logic              pred_ready,
    input  logic              res_valid,
    input  logic              res_taken,
    input  logic [TAG_W-1:0]  res_tag,
    input  logic [ADDR_W-1:0] res_target,
    output logic              res_ready,
    output logic              upd_valid,
    output logic [IDX_W-1:0]  upd_index,
    output logic              upd_taken,
    output logic              btb_wr,
    output logic [IDX_W-1:0]  btb_index,
    output logic [TAG_W-1:0]  btb_tag,
    output logic [ADDR_W-1:0] btb_target,
    output logic              ghr_restore,
    output logic [IDX_W-1:0]  ghr_restore_val,
    output logic              lookup_stall,
    output logic [CNT_W-1:0]  mispred_cnt
);

    ctrl_state_t      state_r;
    ctrl_state_t      state_nxt_s;
    inflight_t        fifo_din_s;
    inflight_t        fifo_head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             push_s;
    logic             pop_s;
    logic             flush_s;
    logic             pred_ready_s;
    logic             res_ready_s;
    logic             mispred_s;

    logic [IDX_W-1:0] head_ghr_r;
    logic             head_taken_r;
    logic             res_taken_r;

    logic             upd_valid_r;
    logic [IDX_W-1:0] upd_index_r;
    logic             upd_taken_r;
    logic             btb_wr_r;
    logic [IDX_W-1:0] btb_index_r;
    logic [TAG_W-1:0] btb_tag_r;
    logic [ADDR_W-1:0] btb_target_r;
    logic             ghr_restore_r;
    logic [IDX_W-1:0] ghr_restore_val_r;
    logic [CNT_W-1:0] mispred_cnt_r;

    // Handshakes come straight from registered state; no full-queue bypass.
    assign pred_ready_s = !fifo_full_s && (state_r != RECOVER);
    assign res_ready_s  = (state_r == IDLE) && !fifo_empty_s;
    assign push_s       = pred_valid && pred_ready_s;
    assign pop_s        = res_valid && res_ready_s;
    assign flush_s      = (state_r == RECOVER);
    assign mispred_s    = (state_r == UPDATE) && (res_taken_r != head_taken_r);

    assign fifo_din_s.index = pred_index;
    assign fifo_din_s.ghr   = pred_ghr;
    assign fifo_din_s.taken = pred_taken;

    gshare_inflight_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .flush (flush_s),
        .din   (fifo_din_s),
        .head  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Next-state decode: IDLE -> UPDATE on accept, UPDATE -> RECOVER on mispredict.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (pop_s) begin
                    state_nxt_s = UPDATE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            UPDATE: begin
                if (mispred_s) begin
                    state_nxt_s = RECOVER;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RECOVER: state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture the popped entry's history/prediction and the resolved direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_ghr_r   <= {IDX_W{1'b0}};
            head_taken_r <= 1'b0;
            res_taken_r  <= 1'b0;
        end else if (pop_s) begin
            head_ghr_r   <= fifo_head_s.ghr;
            head_taken_r <= fifo_head_s.taken;
            res_taken_r  <= res_taken;
        end
    end

    // PHT and BTB write strobes/data, valid for the single UPDATE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_valid_r  <= 1'b0;
            upd_index_r  <= {IDX_W{1'b0}};
            upd_taken_r  <= 1'b0;
            btb_wr_r     <= 1'b0;
            btb_index_r  <= {IDX_W{1'b0}};
            btb_tag_r    <= {TAG_W{1'b0}};
            btb_target_r <= {ADDR_W{1'b0}};
        end else begin
            upd_valid_r <= pop_s;
            btb_wr_r    <= pop_s && res_taken;
            if (pop_s) begin
                upd_index_r <= fifo_head_s.index;
                upd_taken_r <= res_taken;
            end
            if (pop_s && res_taken) begin
                btb_index_r  <= fifo_head_s.index;
                btb_tag_r    <= res_tag;
                btb_target_r <= res_target;
            end
        end
    end

    // GHR restore strobe, asserted for the single RECOVER cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_restore_r     <= 1'b0;
            ghr_restore_val_r <= {IDX_W{1'b0}};
        end else begin
            ghr_restore_r <= mispred_s;
            if (mispred_s) begin
                ghr_restore_val_r <= corrected_ghr(head_ghr_r, res_taken_r);
            end
        end
    end

    // Saturating mispredict counter, bumped at the end of RECOVER.
    always_ff @(posedge clk) begin
        if (rst) begin
            mispred_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == RECOVER) && (mispred_cnt_r != {CNT_W{1'b1}})) begin
            mispred_cnt_r <= mispred_cnt_r + CNT_W'(1);
        end
    end

    assign pred_ready      = pred_ready_s;
    assign res_ready       = res_ready_s;
    assign lookup_stall    = (state_r == UPDATE);
    assign upd_valid       = upd_valid_r;
    assign upd_index       = upd_index_r;
    assign upd_taken       = upd_taken_r;
    assign btb_wr          = btb_wr_r;
    assign btb_index       = btb_index_r;
    assign btb_tag         = btb_tag_r;
    assign btb_target      = btb_target_r;
    assign ghr_restore     = ghr_restore_r;
    assign ghr_restore_val = ghr_restore_val_r;
    assign mispred_cnt     = mispred_cnt_r;

endmodule

// File: doc/gshare_update_ctrl.md
# gshare_update_ctrl

Sequencing controller for the gshare predictor and its BTB. It tracks in-flight predictions in program order and, when each branch resolves, issues exactly one PHT counter update and an optional BTB fill. On a misprediction it restores the global history register and flushes wrong-path entries. It sits between the fetch-side predictor lookup and the execute-side branch resolution.

## Interface
- IDX_W, 7, PHT index / GHR width
- TAG_W, 24, BTB tag width
- ADDR_W, 32, target address width
- DEPTH, 4, in-flight prediction queue depth (power of two, ≥2)
- CNT_W, 16, mispredict counter width
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- pred_valid  in  1  predictor issued a prediction this cycle
- pred_index  in  IDX_W  PHT index (hash) used for the lookup
- pred_ghr  in  IDX_W  GHR value before the speculative shift
- pred_taken  in  1  predicted direction
- pred_ready  out  1  queue can accept a prediction
- res_valid  in  1  oldest in-flight branch resolved
- res_taken  in  1  actual direction
- res_tag  in  TAG_W  BTB tag of the branch
- res_target  in  ADDR_W  actual target
- res_ready  out  1  controller accepts a resolution
- upd_valid  out  1  one-cycle PHT update strobe
- upd_index  out  IDX_W  PHT entry to update
- upd_taken  out  1  increment (1) / decrement (0)
- btb_wr  out  1  one-cycle BTB write strobe
- btb_index, btb_tag, btb_target  out  IDX_W / TAG_W / ADDR_W  BTB write data
- ghr_restore  out  1  one-cycle GHR overwrite strobe
- ghr_restore_val  out  IDX_W  corrected history
- lookup_stall  out  1  PHT port busy; predictor must not look up
- mispred_cnt  out  CNT_W  saturating mispredict count

## Operation
- Queue entry: {index, ghr, taken}. A push occurs on pred_valid && pred_ready. A pop of the head occurs on res_valid && res_ready.
- FSM states: IDLE, UPDATE, RECOVER.
- IDLE: res_ready = !empty. On an accepted resolution, latch the head entry and the res_* fields, pop the head, and go to UPDATE.
- UPDATE, one cycle:
  - upd_valid=1, upd_index=head.index, upd_taken=res_taken.
  - btb_wr=1 only if res_taken, with btb_index=head.index, btb_tag=res_tag, btb_target=res_target.
  - If res_taken != head.taken, go to RECOVER; otherwise go to IDLE.
- RECOVER, one cycle:
  - ghr_restore=1, ghr_restore_val={head.ghr[IDX_W-2:0], res_taken}.
  - Flush the queue (count←0, pointers←0), including any entry pushed during UPDATE.
  - mispred_cnt += 1, saturating at all-ones.
  - Go to IDLE.
- pred_ready = !full && state != RECOVER. A push and a pop in the same cycle are both honoured. A full queue gives pred_ready=0 even when a pop occurs that cycle; there is no bypass.
- lookup_stall = (state == UPDATE).
- A resolution presented when empty (res_valid=1, res_ready=0) is ignored and causes no state change.
- Pointers wrap modulo DEPTH. Occupancy count is clog2(DEPTH+1) bits.

## Timing
- Reset (rst=1 at a clock edge):
  - state=IDLE, queue empty, mispred_cnt=0.
  - All strobes 0; upd_index, upd_taken, btb_* and ghr_restore_val are 0.
  - pred_ready=1, res_ready=0, lookup_stall=0.
- Reset mid-operation overrides every state, and pending updates are dropped.
- Latency from a resolution accepted at edge N:
  - upd_valid and btb_wr are high in cycle N+1.
  - ghr_restore is high in cycle N+2 on a mispredict, and mispred_cnt is visible from N+3.
- Throughput: one resolution per 2 cycles when correctly predicted, one per 3 cycles when mispredicted. res_ready=0 in UPDATE and RECOVER.
- pred_ready, res_ready and lookup_stall are combinational from registered state. All other outputs are registered.

## Structure
- gshare_pkg holds:
  - IDX_W, TAG_W, ADDR_W
  - typedef enum ctrl_state_t {IDLE, UPDATE, RECOVER}
  - typedef struct inflight_t {index, ghr, taken}
- Sub-module gshare_inflight_fifo is a synchronous FIFO of inflight_t with push, pop, flush, full and empty. Flush has priority over push.

## Test plan
- Reset, then push idx=7'h07, ghr=0, taken=0, and resolve not-taken → upd_valid for 1 cycle with upd_index=7, upd_taken=0, btb_wr=0, no ghr_restore, mispred_cnt=0.
- Push idx=7'h38, ghr=7'h01, taken=0, and resolve taken with tag=0, target=32'hD:
  - UPDATE cycle: btb_wr=1, btb_target=32'hD.
  - Next cycle: ghr_restore_val=7'h03.
  - Afterwards: mispred_cnt=1.
- Push 4 predictions → pred_ready=0. A 5th pred_valid is not stored. Resolve all 4 correctly → 4 upd strobes in push order, with indices matching.
- Push 3, mispredict the first, and push 1 more during UPDATE → RECOVER flushes everything, and res_ready=0 afterwards (queue empty).
- res_valid with an empty queue → no strobes and no state change. Assert rst during UPDATE → next cycle all strobes 0, pred_ready=1.
- Preload mispred_cnt near saturation (or run 2^CNT_W mispredicts in a reduced-CNT_W build) → the count holds at all-ones.
